// File: rtl/fabosc_seq_pkg.sv
// Shared types and constants for the fabric-oscillator reset sequencer.
// State codes are fixed because STATE is exported for debug.
package fabosc_seq_pkg;

    localparam int CNT_W  = 16;
    localparam int LOSS_W = 8;
    localparam logic [LOSS_W-1:0] LOSS_SAT = {LOSS_W{1'b1}};

    localparam int DEF_SYNC_STAGES        = 2;
    localparam int DEF_LOCK_STABLE_CYCLES = 1024;
    localparam int DEF_MSS_TIMEOUT_CYCLES = 50000;
    localparam int DEF_FAB_RST_HOLD       = 16;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK   = 3'd0,
        ST_LOCK_STABLE = 3'd1,
        ST_WAIT_MSS    = 3'd2,
        ST_HOLD        = 3'd3,
        ST_RUN         = 3'd4,
        ST_ERROR       = 3'd5
    } seq_state_e;

    // A state lasting len cycles leaves when the cycle counter shows len-1.
    function automatic logic [CNT_W-1:0] last_cycle(input int unsigned len);
        return CNT_W'(len - 1);
    endfunction

endpackage

// File: rtl/fabosc_bit_sync.sv
// Single-bit multi-flop synchroniser with asynchronous active-high clear.
module fabosc_bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/fabosc_reset_sequencer.sv
// Releases FAB_RESET_N once the CCC lock has been stable and the MSS is ready.
// state        | meaning
// WAIT_LOCK  0 | waiting for synchronised CCC lock
// LOCK_STABLE 1| lock must stay high for LOCK_STABLE_CYCLES
// WAIT_MSS   2 | waiting for MSS ready, bounded by MSS_TIMEOUT_CYCLES
// HOLD       3 | fabric reset held low for FAB_RST_HOLD cycles
// RUN        4 | fabric released; lock loss restarts the sequence
// ERROR      5 | MSS timeout, terminal until RESET
module fabosc_reset_sequencer
    import fabosc_seq_pkg::*;
#(
    parameter int SYNC_STAGES        = DEF_SYNC_STAGES,
    parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
    parameter int MSS_TIMEOUT_CYCLES = DEF_MSS_TIMEOUT_CYCLES,
    parameter int FAB_RST_HOLD       = DEF_FAB_RST_HOLD
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              CCC_LOCK,
    input  logic              MSS_READY,
    output logic              FAB_RESET_N,
    output logic              INIT_DONE,
    output logic              TIMEOUT_ERR,
    output logic [2:0]        STATE,
    output logic [LOSS_W-1:0] LOCK_LOSS_CNT
);

    localparam logic [CNT_W-1:0] LOCK_LAST    = last_cycle(LOCK_STABLE_CYCLES);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = last_cycle(MSS_TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LAST    = last_cycle(FAB_RST_HOLD);

    logic lock_s;
    logic mss_s;

    seq_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              fab_reset_n_q, fab_reset_n_d;
    logic              init_done_q, init_done_d;
    logic              timeout_err_q, timeout_err_d;
    logic [LOSS_W-1:0] loss_cnt_q, loss_cnt_d;

    fabosc_bit_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk (CLK),
        .rst (RESET),
        .d   (CCC_LOCK),
        .q   (lock_s)
    );

    fabosc_bit_sync #(.STAGES(SYNC_STAGES)) u_mss_sync (
        .clk (CLK),
        .rst (RESET),
        .d   (MSS_READY),
        .q   (mss_s)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q       <= ST_WAIT_LOCK;
            cnt_q         <= '0;
            fab_reset_n_q <= 1'b0;
            init_done_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            loss_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            fab_reset_n_q <= fab_reset_n_d;
            init_done_q   <= init_done_d;
            timeout_err_q <= timeout_err_d;
            loss_cnt_q    <= loss_cnt_d;
        end
    end

    // Lock loss outranks everything except ERROR; MSS ready outranks the timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = ST_LOCK_STABLE;
                end
            end
            ST_LOCK_STABLE: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (cnt_q == LOCK_LAST) begin
                    state_d = ST_WAIT_MSS;
                end
            end
            ST_WAIT_MSS: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (mss_s) begin
                    state_d = ST_HOLD;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = ST_ERROR;
                end
            end
            ST_HOLD: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_WAIT_LOCK;
            end
        endcase
    end

    // Outputs are registered from the next state so they move with the transition.
    always_comb begin
        cnt_d         = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
        fab_reset_n_d = (state_d == ST_RUN);
        init_done_d   = fab_reset_n_d;
        timeout_err_d = timeout_err_q | (state_d == ST_ERROR);
        loss_cnt_d    = loss_cnt_q;
        if ((state_q == ST_RUN) && !lock_s && (loss_cnt_q != LOSS_SAT)) begin
            loss_cnt_d = loss_cnt_q + LOSS_W'(1);
        end
    end

    assign FAB_RESET_N   = fab_reset_n_q;
    assign INIT_DONE     = init_done_q;
    assign TIMEOUT_ERR   = timeout_err_q;
    assign STATE         = state_q;
    assign LOCK_LOSS_CNT = loss_cnt_q;

endmodule

// File: tb/tb_fabosc_reset_sequencer.sv
// Bench for fabosc_reset_sequencer: directed timing scenarios plus random
// lock/ready activity checked every cycle against a behavioural model.
module tb_fabosc_reset_sequencer;

    localparam int SYNC    = 2;
    localparam int LSC     = 8;
    localparam int MTO     = 32;
    localparam int HOLD    = 4;
    localparam int NOM_LAT = SYNC + LSC + HOLD + 1;

    localparam int P_WAIT_LOCK   = 0;
    localparam int P_LOCK_STABLE = 1;
    localparam int P_WAIT_MSS    = 2;
    localparam int P_HOLD        = 3;
    localparam int P_RUN         = 4;
    localparam int P_ERROR       = 5;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       CCC_LOCK;
    logic       MSS_READY;
    logic       FAB_RESET_N;
    logic       INIT_DONE;
    logic       TIMEOUT_ERR;
    logic [2:0] STATE;
    logic [7:0] LOCK_LOSS_CNT;

    int n_chk   = 0;
    int n_pass  = 0;
    int edge_no = 0;

    // reference model: input history queues, phase, entry edge, counters
    bit lock_hist[$];
    bit mss_hist[$];
    int m_phase;
    int m_entered;
    int m_loss;
    bit m_fab;
    bit m_err;

    fabosc_reset_sequencer #(
        .SYNC_STAGES        (SYNC),
        .LOCK_STABLE_CYCLES (LSC),
        .MSS_TIMEOUT_CYCLES (MTO),
        .FAB_RST_HOLD       (HOLD)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .CCC_LOCK      (CCC_LOCK),
        .MSS_READY     (MSS_READY),
        .FAB_RESET_N   (FAB_RESET_N),
        .INIT_DONE     (INIT_DONE),
        .TIMEOUT_ERR   (TIMEOUT_ERR),
        .STATE         (STATE),
        .LOCK_LOSS_CNT (LOCK_LOSS_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, act, exp, edge_no);
    endtask

    task automatic model_reset();
        lock_hist.delete();
        mss_hist.delete();
        for (int i = 0; i < SYNC; i++) begin
            lock_hist.push_back(1'b0);
            mss_hist.push_back(1'b0);
        end
        m_phase   = P_WAIT_LOCK;
        m_entered = edge_no;
        m_loss    = 0;
        m_fab     = 1'b0;
        m_err     = 1'b0;
    endtask

    // One clock edge of the reference behaviour, using the inputs present at the edge.
    task automatic model_edge();
        bit ls, ms;
        int nxt, age;
        if (RESET) begin
            model_reset();
            return;
        end
        ls = lock_hist[SYNC-1];
        ms = mss_hist[SYNC-1];
        lock_hist.push_front(CCC_LOCK);
        void'(lock_hist.pop_back());
        mss_hist.push_front(MSS_READY);
        void'(mss_hist.pop_back());
        age = edge_no - m_entered;
        nxt = m_phase;
        if (m_phase == P_ERROR) begin
            nxt = P_ERROR;
        end else if (!ls) begin
            if (m_phase == P_RUN && m_loss < 255) m_loss = m_loss + 1;
            nxt = P_WAIT_LOCK;
        end else begin
            case (m_phase)
                P_WAIT_LOCK:   nxt = P_LOCK_STABLE;
                P_LOCK_STABLE: if (age == LSC - 1) nxt = P_WAIT_MSS;
                P_WAIT_MSS:    if (ms) nxt = P_HOLD; else if (age == MTO - 1) nxt = P_ERROR;
                P_HOLD:        if (age == HOLD - 1) nxt = P_RUN;
                default:       nxt = m_phase;
            endcase
        end
        if (nxt != m_phase) m_entered = edge_no + 1;
        m_phase = nxt;
        m_fab   = (nxt == P_RUN);
        if (nxt == P_ERROR) m_err = 1'b1;
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        edge_no++;
        @(negedge CLK);
        chk("state", STATE, m_phase);
        chk("fab_reset_n", FAB_RESET_N, m_fab);
        chk("init_done", INIT_DONE, m_fab);
        chk("timeout_err", TIMEOUT_ERR, m_err);
        chk("lock_loss_cnt", LOCK_LOSS_CNT, m_loss);
    endtask

    task automatic apply_reset();
        RESET = 1'b1;
        model_reset();
        repeat (3) step();
        RESET = 1'b0;
    endtask

    task automatic run_nominal(input string tag);
        int e;
        int last;
        int walk[$];
        MSS_READY = 1'b1;
        CCC_LOCK  = 1'b0;
        repeat (3) step();
        walk.push_back(STATE);
        last = STATE;
        CCC_LOCK = 1'b1;
        e = 0;
        step();
        while (FAB_RESET_N !== 1'b1 && e < 100) begin
            if (STATE != last) begin
                walk.push_back(STATE);
                last = STATE;
            end
            step();
            e++;
        end
        if (STATE != last) walk.push_back(STATE);
        chk({tag, "_latency"}, e, NOM_LAT);
        chk({tag, "_init_done"}, INIT_DONE, 1);
        chk({tag, "_timeout_err"}, TIMEOUT_ERR, 0);
        chk({tag, "_walk_len"}, walk.size(), 5);
        for (int i = 0; i < 5 && i < walk.size(); i++) chk({tag, "_walk"}, walk[i], i);
    endtask

    initial begin
        int g, rise, n, e, to_edge, n_wait, p_lock, p_mss;
        bit seen_ls, saw_restart;
        RESET     = 1'b0;
        CCC_LOCK  = 1'b0;
        MSS_READY = 1'b0;
        apply_reset();
        chk("rst_state", STATE, P_WAIT_LOCK);
        chk("rst_fab_reset_n", FAB_RESET_N, 0);
        chk("rst_init_done", INIT_DONE, 0);
        chk("rst_timeout_err", TIMEOUT_ERR, 0);
        chk("rst_loss_cnt", LOCK_LOSS_CNT, 0);

        run_nominal("nominal");

        // lock glitch of 3 cycles while in LOCK_STABLE
        apply_reset();
        MSS_READY = 1'b1;
        CCC_LOCK  = 1'b0;
        repeat (3) step();
        g = $urandom_range(1, 8);
        rise = -1;
        seen_ls = 1'b0;
        saw_restart = 1'b0;
        for (int k = 0; k < 200; k++) begin
            CCC_LOCK = !(k >= g && k < g + 3);
            step();
            if (STATE == P_LOCK_STABLE) seen_ls = 1'b1;
            if (seen_ls && STATE == P_WAIT_LOCK) saw_restart = 1'b1;
            if (FAB_RESET_N === 1'b1) begin
                rise = k;
                break;
            end
        end
        chk("glitch_restart", saw_restart, 1);
        chk("glitch_latency", rise, g + 3 + NOM_LAT);

        // MSS timeout
        apply_reset();
        MSS_READY = 1'b0;
        CCC_LOCK  = 1'b0;
        repeat (3) step();
        CCC_LOCK = 1'b1;
        n_wait = 0;
        to_edge = -1;
        for (int k = 0; k < 200; k++) begin
            step();
            if (STATE == P_WAIT_MSS) n_wait++;
            if (STATE == P_ERROR) begin
                to_edge = k;
                break;
            end
        end
        chk("to_wait_mss_cycles", n_wait, MTO);
        chk("to_edge", to_edge, SYNC + LSC + MTO);
        chk("to_flag", TIMEOUT_ERR, 1);
        MSS_READY = 1'b1;
        for (int k = 0; k < 20; k++) begin
            CCC_LOCK = 1'($urandom_range(0, 1));
            step();
        end
        chk("to_terminal_state", STATE, P_ERROR);
        chk("to_terminal_fab", FAB_RESET_N, 0);
        chk("to_terminal_flag", TIMEOUT_ERR, 1);

        // MSS ready synchronised exactly on the final timeout cycle; drop it in HOLD
        apply_reset();
        MSS_READY = 1'b0;
        CCC_LOCK  = 1'b0;
        repeat (3) step();
        for (int k = 0; k < 60; k++) begin
            CCC_LOCK  = 1'b1;
            MSS_READY = (k >= LSC + MTO) && !(k >= 43 && k <= 46);
            step();
            if (k == SYNC + LSC + MTO - 1) chk("late_mss_pre", STATE, P_WAIT_MSS);
            if (k == SYNC + LSC + MTO) begin
                chk("late_mss_state", STATE, P_HOLD);
                chk("late_mss_flag", TIMEOUT_ERR, 0);
            end
        end
        chk("late_mss_run", FAB_RESET_N, 1);

        // repeated lock loss in RUN until the counter saturates
        apply_reset();
        MSS_READY = 1'b1;
        CCC_LOCK  = 1'b1;
        e = 0;
        while (FAB_RESET_N !== 1'b1 && e < 100) begin
            step();
            e++;
        end
        chk("sat_first_run", FAB_RESET_N, 1);
        for (int i = 0; i < 300; i++) begin
            MSS_READY = 1'b0;
            step();
            MSS_READY = 1'b1;
            repeat (2) step();
            CCC_LOCK = 1'b0;
            n = 0;
            do begin
                step();
                n++;
            end while (FAB_RESET_N === 1'b1 && n < 20);
            chk("loss_latency", n, SYNC + 1);
            repeat ($urandom_range(0, 2)) step();
            CCC_LOCK = 1'b1;
            e = 0;
            while (FAB_RESET_N !== 1'b1 && e < 100) begin
                step();
                e++;
            end
            chk("relock_run", FAB_RESET_N, 1);
        end
        chk("loss_sat", LOCK_LOSS_CNT, 255);

        // asynchronous reset in the middle of HOLD
        MSS_READY = 1'b1;
        CCC_LOCK  = 1'b0;
        repeat (4) step();
        CCC_LOCK = 1'b1;
        repeat (13) step();
        chk("midhold_state", STATE, P_HOLD);
        #2 RESET = 1'b1;
        #1;
        chk("async_rst_fab", FAB_RESET_N, 0);
        chk("async_rst_init", INIT_DONE, 0);
        chk("async_rst_state", STATE, P_WAIT_LOCK);
        chk("async_rst_loss", LOCK_LOSS_CNT, 0);
        model_reset();
        repeat (2) step();
        RESET = 1'b0;
        run_nominal("rerun");

        // random lock/ready activity with per-episode toggle rates
        for (int ep = 0; ep < 30; ep++) begin
            apply_reset();
            p_lock = $urandom_range(6, 80);
            p_mss  = $urandom_range(6, 80);
            CCC_LOCK  = 1'($urandom_range(0, 1));
            MSS_READY = 1'($urandom_range(0, 1));
            for (int c = 0; c < 300; c++) begin
                if ($urandom_range(0, p_lock - 1) == 0) CCC_LOCK = !CCC_LOCK;
                if ($urandom_range(0, p_mss - 1) == 0) MSS_READY = !MSS_READY;
                step();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached at edge %0d", edge_no);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fabosc_reset_sequencer.md
Name: fabosc_reset_sequencer

Overview:
Consumes the 25/50 MHz on-chip RC oscillator fabric clock (RCOSC_25_50MHZ_O2F) and sequences the fabric reset release. It synchronises the CCC lock and MSS-ready indications and enforces a lock-stability window and an MSS-ready timeout. It then releases FAB_RESET_N after a hold period. Sits directly downstream of the FABOSC oscillator block, ahead of all fabric logic clocked from it.

Parameters:
SYNC_STAGES, 2, flip-flop depth of each input synchroniser (min 2)
LOCK_STABLE_CYCLES, 1024, cycles CCC_LOCK must stay high before proceeding (1..65535)
MSS_TIMEOUT_CYCLES, 50000, cycles allowed for MSS_READY (1 ms at 50 MHz; 1..65535)
FAB_RST_HOLD, 16, cycles FAB_RESET_N is held low after all conditions are met (1..65535)

Ports:
CLK  in  1  fabric oscillator clock (RCOSC_25_50MHZ_O2F)
RESET  in  1  asynchronous, active-high reset
CCC_LOCK  in  1  CCC/PLL lock, asynchronous to CLK
MSS_READY  in  1  MSS ready indication, asynchronous to CLK
FAB_RESET_N  out  1  fabric reset, active low, registered
INIT_DONE  out  1  high while in RUN, registered
TIMEOUT_ERR  out  1  sticky MSS timeout flag
STATE  out  3  current state encoding (debug)
LOCK_LOSS_CNT  out  8  saturating count of lock losses seen in RUN

Behaviour:
- One clock (CLK). RESET is asynchronous and active-high. All flops clear asynchronously on RESET.
- Reset values:
  - FAB_RESET_N=0, INIT_DONE=0, TIMEOUT_ERR=0, LOCK_LOSS_CNT=0.
  - STATE=WAIT_LOCK.
  - Synchroniser flops=0.
- FAB_RESET_N drops to 0 immediately on RESET assertion.
- CCC_LOCK and MSS_READY each pass through a SYNC_STAGES-deep synchroniser, producing lock_s and mss_s. Only the synchronised values are used.
- A single 16-bit cycle counter clears on every state change and increments each cycle otherwise.
- A state with a length of N cycles exits when cnt==N-1.
- States and encoding: WAIT_LOCK=0, LOCK_STABLE=1, WAIT_MSS=2, HOLD=3, RUN=4, ERROR=5. Codes 6 and 7 go to WAIT_LOCK.
- WAIT_LOCK: if lock_s=1, go to LOCK_STABLE.
- LOCK_STABLE:
  - If lock_s=0, go to WAIT_LOCK.
  - Otherwise, when cnt==LOCK_STABLE_CYCLES-1, go to WAIT_MSS.
- WAIT_MSS, in priority order:
  - lock_s=0: go to WAIT_LOCK.
  - mss_s=1: go to HOLD.
  - cnt==MSS_TIMEOUT_CYCLES-1: go to ERROR.
  - If mss_s rises on the timeout cycle, HOLD wins.
- HOLD:
  - If lock_s=0, go to WAIT_LOCK.
  - Otherwise, when cnt==FAB_RST_HOLD-1, go to RUN.
  - MSS_READY dropping during HOLD is ignored.
- RUN: if lock_s=0, go to WAIT_LOCK and increment LOCK_LOSS_CNT, saturating at 255. MSS_READY dropping during RUN is ignored.
- ERROR: terminal until RESET; all inputs are ignored.
- Outputs are registered from next-state and change on the same edge as the state transition:
  - FAB_RESET_N=1 only when next state is RUN.
  - INIT_DONE = FAB_RESET_N.
  - TIMEOUT_ERR=1 once next state is ERROR.
- Latency: take the first edge sampling CCC_LOCK=1 as edge 0, with MSS_READY already high and stable. FAB_RESET_N then rises at edge SYNC_STAGES+LOCK_STABLE_CYCLES+FAB_RST_HOLD+1.
- Lock loss in RUN: lock_s falls at edge k, and FAB_RESET_N and INIT_DONE go to 0 at edge k+1.
- Glitches on CCC_LOCK shorter than one CLK period may be missed. Any lock_s low cycle in LOCK_STABLE restarts the stability window from 0.

Decomposition:
- Package fabosc_seq_pkg:
  - State enum with explicit 3-bit encodings.
  - Counter width constant (16).
  - LOCK_LOSS_CNT width (8) and saturation value.
  - Default parameter constants.
- One sub-module, fabosc_bit_sync: a SYNC_STAGES-deep single-bit synchroniser with async active-high clear. Instantiated twice.

Test Plan:
- Bench parameters: SYNC_STAGES=2, LOCK_STABLE_CYCLES=8, MSS_TIMEOUT_CYCLES=32, FAB_RST_HOLD=4.
- Nominal: MSS_READY=1, CCC_LOCK rises sampled at edge 0 -> FAB_RESET_N and INIT_DONE rise at edge 15; STATE walks 0,1,2,3,4; TIMEOUT_ERR stays 0.
- Lock glitch: CCC_LOCK low for 3 cycles during LOCK_STABLE -> STATE returns to 0 and the 8-cycle window restarts; FAB_RESET_N is delayed by exactly the lost cycles plus resync.
- Timeout: CCC_LOCK=1, MSS_READY=0 -> exactly 32 cycles in WAIT_MSS, then STATE=5 and TIMEOUT_ERR=1. A later MSS_READY=1 leaves FAB_RESET_N=0 until RESET.
- MSS_READY arriving on the final timeout cycle (synchronised edge at cnt==31) -> STATE=3 (HOLD) and TIMEOUT_ERR=0.
- Lock loss in RUN 300 times -> LOCK_LOSS_CNT saturates at 255. Each loss drives FAB_RESET_N low one edge after lock_s falls, then the sequence re-runs.
- RESET asserted mid-HOLD, asynchronously between edges -> outputs clear immediately with STATE=0 and LOCK_LOSS_CNT=0; after release the full sequence repeats with the same edge-15 timing.
